// File: rtl/dstb_busctl.sv
// dstb_busctl -- 68000 bus accelerator controller for DSTB boards.
//
// Decodes NWIN programmable alt-RAM windows and a small config register block.
// It requests SDRAM cycles from the SDRAM controller and generates DTACK_N.
// It also adds per-window wait states and selects the CPU clock.
// The CPU clock is either a divided CLKOSC or the resynchronised ST CLK8.
//
// Optional feature macro: DSTB_BUSCTL_WDOG_EN
//   When this macro is defined, a bus watchdog is built in. A cycle that hangs
//   in DECODE/RAM/WAIT/PASS for TIMEOUT clocks gets BERR_N.
//   When it is not defined, BERR_N is tied high.
//
// Ports
//   CLKOSC     in   master oscillator; state on posedge (CLK8 resync on negedge)
//   RST        in   asynchronous reset, active high
//   AS_N       in   68k address strobe (asynchronous, synchronised here)
//   RW         in   1 = read, 0 = write
//   A[23:1]    in   68k address bus
//   D[7:0]     in   data bus, used for config register writes
//   CLK8       in   ST 8 MHz bus clock
//   SDRAM_ACK  in   single-cycle completion pulse from the SDRAM controller
//   SDRAM_REQ  out  SDRAM cycle request, held until SDRAM_ACK
//   WIN_HIT    out  one-hot window hit, valid through RAM/WAIT/ACK of RAM cycles
//   DTACK_N    out  data acknowledge
//   BERR_N     out  bus error
//   CLKOUT     out  CPU clock, registered and glitch-free
//
// Config register map (word offset A[3:1] within CFG_BASE):
//   0..NWIN-1  window config {en, ws[2:0], nib[3:0]}
//   7          bit 0 = fast clock enable
module dstb_busctl #(
  parameter int          NWIN       = 4,
  parameter logic [19:0] CFG_BASE   = 20'hFFFE0,
  parameter int          FAST_HALF  = 2,
  parameter int          SYNC_SHIFT = 3,
  parameter int          TIMEOUT    = 255
) (
  input  logic            CLKOSC,
  input  logic            RST,
  input  logic            AS_N,
  input  logic            RW,
  input  logic [23:1]     A,
  input  logic [7:0]      D,
  input  logic            CLK8,
  input  logic            SDRAM_ACK,
  output logic            SDRAM_REQ,
  output logic [NWIN-1:0] WIN_HIT,
  output logic            DTACK_N,
  output logic            BERR_N,
  output logic            CLKOUT
);

  localparam int FD_W = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;

  generate
    if (NWIN < 1 || NWIN > 7 || FAST_HALF < 1 || SYNC_SHIFT < 2 || TIMEOUT < 1) begin : g_bad_param
      $error("dstb_busctl: parameter out of range");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_CFG, S_RAM, S_WAIT, S_ACK, S_PASS, S_BERR
  } state_t;

  state_t          state_q, state_d;
  logic            as_m_q, as_s_q, as_p_q;
  logic            req_q, req_d;
  logic [NWIN-1:0] hit_q, hit_d;
  logic            dtack_n_q, dtack_n_d;
  logic [2:0]      wcnt_q, wcnt_d;
  logic [7:0]      win_cfg_q [NWIN];
  logic [7:0]      win_cfg_d [NWIN];
  logic            fast_en_q, fast_en_d;

  logic [NWIN-1:0] raw_hit, first_hit;
  logic [2:0]      hit_ws;
  logic            start, cfg_match, cfg_we;

  logic [SYNC_SHIFT-1:0] clk8_sync_q, clk8_sync_d;
  logic [FD_W-1:0]       fdiv_q, fdiv_d;
  logic                  fast_q, fast_d;
  logic                  sel_q, sel_d;
  logic                  clkout_q, clkout_d;
  logic                  slow, want_fast;

`ifdef DSTB_BUSCTL_WDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            berr_n_q, berr_n_d;
`endif

  // Start of a bus cycle is the synchronised strobe falling.
  assign start     = as_p_q & ~as_s_q;
  assign cfg_match = (A[23:4] == CFG_BASE);
  assign cfg_we    = (state_q == S_CFG) && !RW;

  genvar gi;
  generate
    for (gi = 0; gi < NWIN; gi++) begin : g_win
      assign raw_hit[gi] = win_cfg_q[gi][7] && (win_cfg_q[gi][3:0] == A[23:20]);
    end
  endgenerate

  // Isolate the lowest set bit, so the lowest-index window wins overlaps.
  assign first_hit = raw_hit & (~raw_hit + NWIN'(1));

  always_comb begin
    hit_ws = 3'd0;
    for (int w = 0; w < NWIN; w++) begin
      if (hit_q[w]) hit_ws = hit_ws | win_cfg_q[w][6:4];
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    fast_en_d = fast_en_q;
    for (int w = 0; w < NWIN; w++) begin
      win_cfg_d[w] = win_cfg_q[w];
      if (cfg_we && A[3:1] == 3'(w)) win_cfg_d[w] = D;
    end
    if (cfg_we && A[3:1] == 3'd7) fast_en_d = D[0];

    case (state_q)
      S_IDLE:   if (start) state_d = S_DECODE;
      S_DECODE: begin
        if (cfg_match)       state_d = S_CFG;
        else if (|first_hit) state_d = S_RAM;
        else                 state_d = S_PASS;
      end
      S_CFG:    state_d = S_ACK;
      S_RAM: begin
        if (as_s_q) begin
          state_d = S_IDLE;
        end else if (SDRAM_ACK) begin
          wcnt_d  = hit_ws;
          state_d = (hit_ws == 3'd0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (as_s_q) begin
          state_d = S_IDLE;
        end else begin
          // Leaving on count 1 makes ws=n add exactly n cycles over ws=0.
          wcnt_d = wcnt_q - 3'd1;
          if (wcnt_q == 3'd1) state_d = S_ACK;
        end
      end
      S_ACK:    if (as_s_q) state_d = S_IDLE;
      S_PASS:   if (as_s_q) state_d = S_IDLE;
      S_BERR:   if (as_s_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

`ifdef DSTB_BUSCTL_WDOG_EN
    if (state_q == S_IDLE)                 wd_cnt_d = '0;
    else if (wd_cnt_q != WD_W'(TIMEOUT))   wd_cnt_d = wd_cnt_q + 1'b1;
    else                                   wd_cnt_d = wd_cnt_q;
    // A legitimate strobe release wins over a coincident timeout.
    if (wd_cnt_d == WD_W'(TIMEOUT) && state_d != S_IDLE &&
        (state_q inside {S_DECODE, S_RAM, S_WAIT, S_PASS}))
      state_d = S_BERR;
    berr_n_d = (state_d != S_BERR);
`endif

    // All bus outputs are registered as a function of the next state.
    // As a result, DTACK_N rises in the same edge that returns to IDLE.
    req_d     = (state_d == S_RAM);
    dtack_n_d = (state_d != S_ACK);
    if (state_d inside {S_RAM, S_WAIT, S_ACK})
      hit_d = (state_q == S_DECODE) ? first_hit : hit_q;
    else
      hit_d = '0;
  end

  // Clock selection. sel may only change while both sources are low.
  // This means the registered output can never produce a runt pulse.
  assign slow      = clk8_sync_q[SYNC_SHIFT-1];
  assign want_fast = fast_en_q && (state_q != S_PASS);

  always_comb begin
    clk8_sync_d = {clk8_sync_q[SYNC_SHIFT-2:0], CLK8};
    fdiv_d      = fdiv_q + 1'b1;
    fast_d      = fast_q;
    if (fdiv_q == FD_W'(FAST_HALF - 1)) begin
      fdiv_d = '0;
      fast_d = ~fast_q;
    end
    sel_d    = (!fast_q && !slow) ? want_fast : sel_q;
    clkout_d = sel_d ? fast_q : slow;
  end

  always_ff @(negedge CLKOSC or posedge RST) begin
    if (RST) clk8_sync_q <= '0;
    else     clk8_sync_q <= clk8_sync_d;
  end

  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      as_m_q    <= 1'b1;
      as_s_q    <= 1'b1;
      as_p_q    <= 1'b1;
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      hit_q     <= '0;
      dtack_n_q <= 1'b1;
      wcnt_q    <= 3'd0;
      fast_en_q <= 1'b1;
      for (int w = 0; w < NWIN; w++) win_cfg_q[w] <= 8'h00;
      fdiv_q    <= '0;
      fast_q    <= 1'b0;
      sel_q     <= 1'b0;
      clkout_q  <= 1'b0;
`ifdef DSTB_BUSCTL_WDOG_EN
      wd_cnt_q  <= '0;
      berr_n_q  <= 1'b1;
`endif
    end else begin
      as_m_q    <= AS_N;
      as_s_q    <= as_m_q;
      as_p_q    <= as_s_q;
      state_q   <= state_d;
      req_q     <= req_d;
      hit_q     <= hit_d;
      dtack_n_q <= dtack_n_d;
      wcnt_q    <= wcnt_d;
      fast_en_q <= fast_en_d;
      for (int w = 0; w < NWIN; w++) win_cfg_q[w] <= win_cfg_d[w];
      fdiv_q    <= fdiv_d;
      fast_q    <= fast_d;
      sel_q     <= sel_d;
      clkout_q  <= clkout_d;
`ifdef DSTB_BUSCTL_WDOG_EN
      wd_cnt_q  <= wd_cnt_d;
      berr_n_q  <= berr_n_d;
`endif
    end
  end

  assign SDRAM_REQ = req_q;
  assign WIN_HIT   = hit_q;
  assign DTACK_N   = dtack_n_q;
  assign CLKOUT    = clkout_q;
`ifdef DSTB_BUSCTL_WDOG_EN
  assign BERR_N    = berr_n_q;
`else
  assign BERR_N    = 1'b1;
`endif

endmodule

// File: tb/tb_dstb_busctl.sv
// Testbench for dstb_busctl.
// It covers config writes, window decoding, wait states, pass-through,
// clock switching, abort, and reset behaviour. It also covers the watchdog
// when the design is built with DSTB_BUSCTL_WDOG_EN.
module tb_dstb_busctl;
  localparam int NWIN = 4;
  localparam int NVEC = 20;

  logic            CLKOSC = 1'b0;
  logic            RST = 1'b1;
  logic            AS_N = 1'b1;
  logic            RW = 1'b1;
  logic [23:1]     A = '0;
  logic [7:0]      D = '0;
  logic            CLK8 = 1'b0;
  logic            SDRAM_ACK = 1'b0;
  logic            SDRAM_REQ, DTACK_N, BERR_N, CLKOUT;
  logic [NWIN-1:0] WIN_HIT;

  int checks = 0;
  int errors = 0;

  dstb_busctl #(.NWIN(NWIN)) dut (
    .CLKOSC(CLKOSC), .RST(RST), .AS_N(AS_N), .RW(RW), .A(A), .D(D),
    .CLK8(CLK8), .SDRAM_ACK(SDRAM_ACK), .SDRAM_REQ(SDRAM_REQ),
    .WIN_HIT(WIN_HIT), .DTACK_N(DTACK_N), .BERR_N(BERR_N), .CLKOUT(CLKOUT)
  );

  // CLKOSC has a period of 10. CLK8 has a period of 120 (12 CLKOSC cycles).
  // CLK8 is phase-offset so that its edges never coincide with CLKOSC edges.
  always #5 CLKOSC = ~CLKOSC;
  initial begin
    #3;
    forever #60 CLK8 = ~CLK8;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // No CLKOUT phase may be shorter than one CLKOSC period.
  time last_edge = 0;
  bit  mon_en = 1'b0;
  always @(CLKOUT) begin
    if (mon_en) begin
      checks++;
      if ($time - last_edge < 10) begin
        errors++;
        $display("FAIL clkout_glitch: phase %0t expected >= 10", $time - last_edge);
      end
    end
    last_edge = $time;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLKOSC);
  endtask

  // Returns the CLKOSC cycle count between two CLKOUT rising edges, or -1.
  task automatic meas_period(output int cyc);
    logic prev;
    int   t0;
    cyc  = -1;
    t0   = -1;
    prev = CLKOUT;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLKOSC);
      if (CLKOUT && !prev) begin
        if (t0 < 0) t0 = i;
        else begin
          cyc = i - t0;
          break;
        end
      end
      prev = CLKOUT;
    end
  endtask

  // kind: 0 = no response (pass), 1 = DTACK without request, 2 = SDRAM cycle.
  // lat is the number of clocks from the SDRAM_ACK edge to DTACK_N low.
  // rel is the number of clocks from AS_N release until DTACK_N is high.
  task automatic bus_cycle(input logic rw, input logic [23:0] addr, input logic [7:0] data,
                           output int kind, output logic [NWIN-1:0] hit, output int lat,
                           output logic req_after, output int rel);
    kind = 0; hit = '0; lat = -1; req_after = 1'b0; rel = -1;
    @(negedge CLKOSC);
    RW = rw; A = addr[23:1]; D = data; AS_N = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLKOSC);
      if (SDRAM_REQ) begin kind = 2; break; end
      if (!DTACK_N)  begin kind = 1; break; end
    end
    if (kind == 2) begin
      hit = WIN_HIT;
      SDRAM_ACK = 1'b1;
      for (int i = 0; i < 12; i++) begin
        @(negedge CLKOSC);
        SDRAM_ACK = 1'b0;
        if (i == 0) req_after = SDRAM_REQ;
        if (!DTACK_N) begin lat = i; break; end
      end
    end
    AS_N = 1'b1; RW = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0 || kind != 0) @(negedge CLKOSC);
      if (DTACK_N) begin rel = i; break; end
    end
    tick(3);
  endtask

  typedef struct {
    logic            rw;
    logic [23:0]     addr;
    logic [7:0]      data;
    int              kind;
    logic [NWIN-1:0] hit;
    int              lat;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    int              kind, lat, rel, per, found;
    logic [NWIN-1:0] hit;
    logic            req_after, dt_seen;

    vecs[0]  = '{1'b0, 24'hFFFE00, 8'hC4, 1, 4'b0000, -1}; // win0: en ws4 nib4
    vecs[1]  = '{1'b1, 24'h400000, 8'h00, 2, 4'b0001,  4};
    vecs[2]  = '{1'b0, 24'hFFFE04, 8'h84, 1, 4'b0000, -1}; // win2: en ws0 nib4
    vecs[3]  = '{1'b1, 24'h400010, 8'h00, 2, 4'b0001,  4}; // overlap: lowest wins
    vecs[4]  = '{1'b0, 24'hFFFE00, 8'h00, 1, 4'b0000, -1}; // disable win0
    vecs[5]  = '{1'b1, 24'h4ABCDE, 8'h00, 2, 4'b0100,  0};
    vecs[6]  = '{1'b1, 24'h900000, 8'h00, 0, 4'b0000, -1};
    vecs[7]  = '{1'b0, 24'hFFFE02, 8'hA9, 1, 4'b0000, -1}; // win1: en ws2 nib9
    vecs[8]  = '{1'b1, 24'h912344, 8'h00, 2, 4'b0010,  2};
    vecs[9]  = '{1'b1, 24'hFFFE02, 8'h00, 1, 4'b0000, -1}; // config read writes nothing
    vecs[10] = '{1'b1, 24'h900000, 8'h00, 2, 4'b0010,  2};
    vecs[11] = '{1'b0, 24'hFFFE0A, 8'hFF, 1, 4'b0000, -1}; // offset 5 ignored
    vecs[12] = '{1'b1, 24'hF00000, 8'h00, 0, 4'b0000, -1};
    vecs[13] = '{1'b0, 24'hFFFE06, 8'hF7, 1, 4'b0000, -1}; // win3: en ws7 nib7
    vecs[14] = '{1'b1, 24'h7FFFFE, 8'h00, 2, 4'b1000,  7};
    vecs[15] = '{1'b0, 24'hFFFE06, 8'h8F, 1, 4'b0000, -1}; // win3: en ws0 nibF
    vecs[16] = '{1'b1, 24'hFFFE00, 8'h00, 1, 4'b0000, -1}; // config block beats window
    vecs[17] = '{1'b1, 24'hF00000, 8'h00, 2, 4'b1000,  0};
    vecs[18] = '{1'b0, 24'hFFFE08, 8'hFF, 1, 4'b0000, -1}; // offset 4 ignored
    vecs[19] = '{1'b1, 24'hF00000, 8'h00, 2, 4'b1000,  0};

    // Reset state
    tick(3);
    chk("rst_req",    SDRAM_REQ, 0);
    chk("rst_dtack",  DTACK_N,   1);
    chk("rst_berr",   BERR_N,    1);
    chk("rst_hit",    WIN_HIT,   0);
    chk("rst_clkout", CLKOUT,    0);
    RST = 1'b0;
    mon_en = 1'b1;
    tick(30);
    meas_period(per);
    chk("fast_period_after_reset", per, 4);

    // Table-driven bus cycles
    for (int v = 0; v < NVEC; v++) begin
      bus_cycle(vecs[v].rw, vecs[v].addr, vecs[v].data, kind, hit, lat, req_after, rel);
      $display("vec %0d rw=%0b addr=%h data=%h kind=%0d hit=%b lat=%0d rel=%0d",
               v, vecs[v].rw, vecs[v].addr, vecs[v].data, kind, hit, lat, rel);
      chk($sformatf("vec%0d_kind", v), kind, vecs[v].kind);
      chk($sformatf("vec%0d_hit", v),  hit,  vecs[v].hit);
      chk($sformatf("vec%0d_lat", v),  lat,  vecs[v].lat);
      chk($sformatf("vec%0d_rel", v),  rel,  (vecs[v].kind == 0) ? 0 : 2);
      if (vecs[v].kind == 2) chk($sformatf("vec%0d_req_drop", v), req_after, 0);
      chk($sformatf("vec%0d_idle_req", v), SDRAM_REQ, 0);
      chk($sformatf("vec%0d_idle_hit", v), WIN_HIT, 0);
    end

    // Clock select via fast_en, and slow clock while in PASS
    bus_cycle(1'b0, 24'hFFFE0E, 8'h00, kind, hit, lat, req_after, rel);
    chk("fast_off_kind", kind, 1);
    tick(10);
    meas_period(per);
    chk("slow_period", per, 12);
    bus_cycle(1'b0, 24'hFFFE0E, 8'h01, kind, hit, lat, req_after, rel);
    chk("fast_on_kind", kind, 1);
    tick(10);
    meas_period(per);
    chk("fast_period", per, 4);
    $display("seq clock select: fast_en 0 -> 1 done");

    @(negedge CLKOSC);
    RW = 1'b1; A = 24'h300000 >> 1; AS_N = 1'b0;
    tick(20);
    meas_period(per);
    chk("pass_slow_period", per, 12);
    chk("pass_dtack", DTACK_N, 1);
    chk("pass_req", SDRAM_REQ, 0);
    AS_N = 1'b1;
    tick(20);
    meas_period(per);
    chk("post_pass_fast_period", per, 4);
    $display("seq pass-through clock: done");

    // Strobe released during WAIT aborts the cycle
    bus_cycle(1'b0, 24'hFFFE06, 8'hF7, kind, hit, lat, req_after, rel);
    @(negedge CLKOSC);
    RW = 1'b1; A = 24'h700000 >> 1; AS_N = 1'b0;
    found = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLKOSC);
      if (SDRAM_REQ) begin found = 1; break; end
    end
    chk("abort_req_seen", found, 1);
    SDRAM_ACK = 1'b1;
    @(negedge CLKOSC);
    SDRAM_ACK = 1'b0;
    AS_N = 1'b1;
    dt_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLKOSC);
      if (!DTACK_N) dt_seen = 1'b1;
    end
    chk("abort_no_dtack", dt_seen, 0);
    chk("abort_req", SDRAM_REQ, 0);
    chk("abort_hit", WIN_HIT, 0);
    bus_cycle(1'b1, 24'h700000, 8'h00, kind, hit, lat, req_after, rel);
    chk("after_abort_hit", hit, 4'b1000);
    chk("after_abort_lat", lat, 7);
    $display("seq abort in WAIT: dtack_seen=%0b", dt_seen);

    // Reset while DTACK is asserted
    mon_en = 1'b0;
    @(negedge CLKOSC);
    RW = 1'b0; A = 24'hFFFE0E >> 1; D = 8'h01; AS_N = 1'b0;
    found = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLKOSC);
      if (!DTACK_N) begin found = 1; break; end
    end
    chk("rstack_dtack_seen", found, 1);
    #2 RST = 1'b1;
    #1;
    chk("rstack_dtack_async", DTACK_N, 1);
    chk("rstack_req", SDRAM_REQ, 0);
    chk("rstack_berr", BERR_N, 1);
    AS_N = 1'b1; RW = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(10);
    mon_en = 1'b1;
    bus_cycle(1'b1, 24'h400000, 8'h00, kind, hit, lat, req_after, rel);
    chk("rstack_windows_cleared", kind, 0);
    $display("seq reset in ACK: done");

    // Hung SDRAM cycle (no SDRAM_ACK)
    bus_cycle(1'b0, 24'hFFFE00, 8'hC4, kind, hit, lat, req_after, rel);
    @(negedge CLKOSC);
    RW = 1'b1; A = 24'h400000 >> 1; AS_N = 1'b0;
    dt_seen = 1'b0;
`ifdef DSTB_BUSCTL_WDOG_EN
    found = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge CLKOSC);
      if (!DTACK_N) dt_seen = 1'b1;
      if (!BERR_N) begin found = i; break; end
    end
    chk("wdog_berr_cycle", found, 258);
    chk("wdog_req_dropped", SDRAM_REQ, 0);
    AS_N = 1'b1;
    found = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLKOSC);
      if (!DTACK_N) dt_seen = 1'b1;
      if (BERR_N) begin found = i; break; end
    end
    chk("wdog_berr_release", found, 2);
    chk("wdog_no_dtack", dt_seen, 0);
`else
    for (int i = 0; i < 300; i++) begin
      @(negedge CLKOSC);
      if (!DTACK_N) dt_seen = 1'b1;
    end
    chk("hang_berr", BERR_N, 1);
    chk("hang_req_held", SDRAM_REQ, 1);
    AS_N = 1'b1;
    tick(4);
    chk("hang_release_req", SDRAM_REQ, 0);
    chk("hang_release_hit", WIN_HIT, 0);
    chk("hang_no_dtack", dt_seen, 0);
`endif
    $display("seq hung cycle: done");

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
